// File: rtl/led_sched_pkg.sv
// Shared types and constants for the status-LED blink scheduler.
package led_sched_pkg;

  typedef enum logic [2:0] {IDLE, ON, OFF, SOLID, GAP} sched_state_t;

  typedef logic [3:0] pat_code_t;

  localparam pat_code_t   PAT_SOLID = 4'd0;
  localparam int unsigned TCNT_W    = 8;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
module led_tick_gen
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) & cnt_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_en) begin
      if (clr || cnt == LAST) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Arbitrates blink-pattern requests onto the shared status LED and sequences them.
// Define LED_SCHED_RR_EN for round-robin arbitration (default: fixed priority, lowest index).
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_pat,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 done,
  output logic                 LED
);

  localparam int unsigned       TICK_DIV   = CLK_HZ / TICK_HZ;
  localparam logic [TCNT_W-1:0] ON_LAST    = TCNT_W'(ON_TICKS - 1);
  localparam logic [TCNT_W-1:0] OFF_LAST   = TCNT_W'(OFF_TICKS - 1);
  localparam logic [TCNT_W-1:0] SOLID_LAST = TCNT_W'(4 * ON_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(GAP_TICKS - 1);

  sched_state_t        state, state_nxt;
  logic [TCNT_W-1:0]   tick_cnt;
  logic [3:0]          blink_cnt;
  logic                tick, accept, done_nxt;
  logic                win_found;
  logic [2:0]          win_id;
  logic [NUM_REQ-1:0]  win_oh;
  pat_code_t           win_code;

`ifdef LED_SCHED_RR_EN
  logic [2:0] rr_ptr;
`endif

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_en (cnt_en),
    .clr    (accept),
    .tick   (tick)
  );

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    win_code  = PAT_SOLID;
`ifdef LED_SCHED_RR_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (i == (32'(rr_ptr) + k) % NUM_REQ && !win_found && req_valid[i]) begin
          win_found = 1'b1;
          win_id    = 3'(i);
          win_oh[i] = 1'b1;
          win_code  = req_pat[4*i +: 4];
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_id    = 3'(i);
        win_oh[i] = 1'b1;
        win_code  = req_pat[4*i +: 4];
      end
    end
`endif
  end

  // Grant is gated by rst_n as well so no handshake is visible while reset is held.
  assign accept    = win_found & (state == IDLE) & cnt_en & rst_n;
  assign req_ready = accept ? win_oh : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = (win_code == PAT_SOLID) ? SOLID : ON;
      ON:    if (tick && tick_cnt == ON_LAST)
               state_nxt = (blink_cnt == 4'd1) ? GAP : OFF;
      OFF:   if (tick && tick_cnt == OFF_LAST)   state_nxt = ON;
      SOLID: if (tick && tick_cnt == SOLID_LAST) state_nxt = GAP;
      GAP:   if (tick && tick_cnt == GAP_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      LED       <= 1'b0;
      grant_id  <= '0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
`ifdef LED_SCHED_RR_EN
      rr_ptr    <= '0;
`endif
    end else if (cnt_en) begin
      state <= state_nxt;
      done  <= done_nxt;
      LED   <= (state_nxt == ON) || (state_nxt == SOLID);
      if (accept || state_nxt != state || state == IDLE) tick_cnt <= '0;
      else if (tick)                                     tick_cnt <= tick_cnt + 1'b1;
      if (accept) begin
        blink_cnt <= win_code;
        grant_id  <= win_id;
`ifdef LED_SCHED_RR_EN
        rr_ptr    <= (32'(win_id) + 1 >= NUM_REQ) ? '0 : win_id + 3'd1;
`endif
      end else if (state == ON && state_nxt == OFF) begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched: the driver predicts each pattern, the monitor checks the LED waveform.
module tb_led_blink_sched;

  localparam int unsigned NR = 4, DIV = 10, ONT = 2, OFFT = 2, GAPT = 8;

  logic        clk = 1'b0;
  logic        rst_n, cnt_en;
  logic [3:0]  req_valid;
  logic [15:0] req_pat;
  logic [3:0]  req_ready;
  logic        busy, done, LED;
  logic [2:0]  grant_id;

  led_blink_sched #(
    .CLK_HZ(80), .TICK_HZ(8), .NUM_REQ(NR),
    .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .req_valid(req_valid),
    .req_pat(req_pat), .req_ready(req_ready), .busy(busy),
    .grant_id(grant_id), .done(done), .LED(LED)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned code;
    int unsigned stall_at;
    int unsigned stall_len;
    bit          abort;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned model_ptr = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned dur(input int unsigned code);
    if (code == 0) return (4 * ONT + GAPT) * DIV;
    return (code * ONT + (code - 1) * OFFT + GAPT) * DIV;
  endfunction

  // LED level in the k-th cycle after the accepting edge, no stalls.
  function automatic bit level(input int unsigned code, input int unsigned k);
    int unsigned period = (ONT + OFFT) * DIV;
    if (code == 0) return k < 4 * ONT * DIV;
    return (k < code * period - OFFT * DIV) && ((k % period) < ONT * DIV);
  endfunction

  function automatic bit exp_level(input exp_t e, input int unsigned k);
    if (e.stall_len == 0 || k <= e.stall_at) return level(e.code, k);
    if (k <= e.stall_at + e.stall_len)       return level(e.code, e.stall_at);
    return level(e.code, k - e.stall_len);
  endfunction

  function automatic int unsigned predict(input logic [3:0] v);
`ifdef LED_SCHED_RR_EN
    for (int unsigned k = 0; k < NR; k++)
      if (v[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
`else
    for (int unsigned i = 0; i < NR; i++)
      if (v[i]) return i;
`endif
    return 0;
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic run_pat(input logic [3:0] v, input logic [15:0] pat,
                         input bit stall, input int unsigned sl);
    exp_t e;
    @(negedge clk);
    req_valid   = v;
    req_pat     = pat;
    e.id        = predict(v);
    e.code      = int'(pat[4*e.id +: 4]);
    e.abort     = 1'b0;
    e.stall_at  = stall ? $urandom_range(dur(e.code) - 2, 1) : 0;
    e.stall_len = stall ? sl : 0;
    model_ptr   = (e.id + 1) % NR;
    sb.push_back(e);
    @(negedge clk);
    req_valid = '0;
    if (stall) begin
      repeat (e.stall_at) @(negedge clk);
      cnt_en = 1'b0;
      repeat (e.stall_len) @(negedge clk);
      cnt_en = 1'b1;
    end
    wait_idle();
  endtask

  // Monitor: follows each accepted pattern cycle by cycle until done or reset.
  initial begin
    exp_t        cur;
    bit          tracking = 1'b0;
    int unsigned k = 0, errs = 0;
    forever begin
      @(negedge clk);
      #2;
      if (tracking) begin
        if (!rst_n) begin
          check("abort_expected", int'(cur.abort), 1);
          tracking = 1'b0;
        end else if (done) begin
          check("done_abort", int'(cur.abort), 0);
          check("done_latency", int'(k), int'(dur(cur.code) + cur.stall_len));
          check("grant_id", int'(grant_id), int'(cur.id));
          check("led_wave_errs", int'(errs), 0);
          tracking = 1'b0;
        end else begin
          if (LED !== exp_level(cur, k) || busy !== 1'b1 || req_ready !== 4'b0000) begin
            if (errs == 0)
              $display("  led wave deviation at cycle %0d: LED=%b busy=%b ready=%b", k, LED, busy, req_ready);
            errs++;
          end
          k++;
          if (k > dur(cur.code) + cur.stall_len + 5) begin
            check("done_timeout", int'(k), int'(dur(cur.code) + cur.stall_len));
            tracking = 1'b0;
          end
        end
      end else if (done) begin
        check("spurious_done", int'(done), 0);
      end
      if (!tracking && rst_n && (req_valid & req_ready) != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_accept", int'(req_ready), 0);
        end else begin
          cur = sb.pop_front();
          check("grant_onehot", int'(req_ready), 1 << cur.id);
          tracking = 1'b1;
          k        = 0;
          errs     = 0;
        end
      end
    end
  end

  initial begin
    exp_t        e;
    logic [3:0]  v;
    logic [15:0] p;
    rst_n = 1'b0; cnt_en = 1'b1; req_valid = 4'hF; req_pat = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_led", int'(LED), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;

    run_pat(4'b0001, 16'h0003, 1'b0, 0);
    run_pat(4'b1010, 16'h2050, 1'b0, 0);
    run_pat(4'b1010, 16'h2050, 1'b0, 0);
    run_pat(4'b0100, 16'h5055, 1'b0, 0);
    run_pat(4'b0001, 16'h0003, 1'b1, 15);

    @(negedge clk);
    cnt_en = 1'b0; req_valid = 4'b0001;
    #1 check("ready_frozen", int'(req_ready), 0);
    @(negedge clk);
    req_valid = '0; cnt_en = 1'b1;

    for (int n = 0; n < 25; n++) begin
      v = 4'($urandom_range(15, 1));
      p = 16'($urandom);
      run_pat(v, p, 1'($urandom), $urandom_range(20, 1));
    end

    @(negedge clk);
    req_valid = 4'b0010; req_pat = 16'h0030;
    e.id = 1; e.code = 3; e.stall_at = 0; e.stall_len = 0; e.abort = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = '0;
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    #2;
    check("abort_led", int'(LED), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (300) @(negedge clk);

    run_pat(4'b1001, 16'h1002, 1'b0, 0);
    run_pat(4'b1001, 16'h1002, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
